// File: rtl/mem_wb_skid.sv
// Purpose: MEM->WB pipeline register with a two-entry skid (main + skid), optional stall counter (MEM_WB_STALL_CNT_EN).
// Latency: one cycle from accept to validOut; zero bubbles under continuous validIn/readyIn.
// Backpressure: readyOut drops only when both entries are held; it is decoded from registered state, never from readyIn.
module mem_wb_skid #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         validIn,
    output logic         readyOut,
    input  logic         WB_ENIn,
    input  logic         MEM_R_ENIn,
    input  logic [3:0]   DestIn,
    input  logic [N-1:0] ALU_ResIn,
    input  logic [N-1:0] DataMemoryIn,
    input  logic         flush,
    output logic         validOut,
    input  logic         readyIn,
    output logic         WB_ENOut,
    output logic         MEM_R_ENOut,
    output logic [3:0]   DestOut,
    output logic [N-1:0] WB_ValueOut
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [15:0]  stallCountOut
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic         wb_en;
        logic         mem_r_en;
        logic [3:0]   dest;
        logic [N-1:0] value;
    } entry_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   accept;
    logic   retire;

    // Select the write-back value at capture time so the WB side only sees one word.
    always_comb begin
        in_entry.wb_en    = WB_ENIn;
        in_entry.mem_r_en = MEM_R_ENIn;
        in_entry.dest     = DestIn;
        in_entry.value    = MEM_R_ENIn ? DataMemoryIn : ALU_ResIn;
    end

    assign readyOut = (state != FULL);
    assign validOut = (state != EMPTY);
    assign accept   = validIn & readyOut;
    assign retire   = validOut & readyIn;

    assign WB_ENOut    = main_q.wb_en & validOut;
    assign MEM_R_ENOut = main_q.mem_r_en;
    assign DestOut     = main_q.dest;
    assign WB_ValueOut = main_q.value;

    // Occupancy FSM: main always holds the oldest entry, skid the younger one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            // Data is left stale; only the occupancy is dropped.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_entry;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        skid_q <= in_entry;
                        state  <= FULL;
                    end else if (retire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (retire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Saturating count of cycles where MEM is blocked; survives flush, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (validIn && !readyOut && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stallCountOut = stall_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_skid.sv
module tb_mem_wb_skid;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         validIn;
    logic         readyOut;
    logic         WB_ENIn;
    logic         MEM_R_ENIn;
    logic [3:0]   DestIn;
    logic [N-1:0] ALU_ResIn;
    logic [N-1:0] DataMemoryIn;
    logic         flush;
    logic         validOut;
    logic         readyIn;
    logic         WB_ENOut;
    logic         MEM_R_ENOut;
    logic [3:0]   DestOut;
    logic [N-1:0] WB_ValueOut;
`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0]  stallCountOut;
`endif

    mem_wb_skid #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .validIn      (validIn),
        .readyOut     (readyOut),
        .WB_ENIn      (WB_ENIn),
        .MEM_R_ENIn   (MEM_R_ENIn),
        .DestIn       (DestIn),
        .ALU_ResIn    (ALU_ResIn),
        .DataMemoryIn (DataMemoryIn),
        .flush        (flush),
        .validOut     (validOut),
        .readyIn      (readyIn),
        .WB_ENOut     (WB_ENOut),
        .MEM_R_ENOut  (MEM_R_ENOut),
        .DestOut      (DestOut),
        .WB_ValueOut  (WB_ValueOut)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .stallCountOut(stallCountOut)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wb;
        logic         mr;
        logic [3:0]   dest;
        logic [N-1:0] val;
    } ent_t;

    ent_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    logic [15:0] stall_m = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded FIFO of at most two entries; flush/reset empty it.
    always @(posedge clk) begin : model
        ent_t e;
        bit   acc;
        bit   ret;
        acc = validIn && (exp_q.size() < 2);
        ret = readyIn && (exp_q.size() > 0);
        if (rst) begin
            exp_q.delete();
            stall_m = '0;
        end else begin
            if (validIn && exp_q.size() == 2 && stall_m != 16'hFFFF)
                stall_m = stall_m + 16'd1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (ret) void'(exp_q.pop_front());
                if (acc) begin
                    e.wb   = WB_ENIn;
                    e.mr   = MEM_R_ENIn;
                    e.dest = DestIn;
                    e.val  = MEM_R_ENIn ? DataMemoryIn : ALU_ResIn;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: compares what the DUT presents against the head of the expected queue.
    always @(negedge clk) begin
        if (chk_en) begin
            check("readyOut", 64'(readyOut), 64'(exp_q.size() < 2));
            check("validOut", 64'(validOut), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("WB_ValueOut", 64'(WB_ValueOut), 64'(exp_q[0].val));
                check("DestOut", 64'(DestOut), 64'(exp_q[0].dest));
                check("MEM_R_ENOut", 64'(MEM_R_ENOut), 64'(exp_q[0].mr));
                check("WB_ENOut", 64'(WB_ENOut), 64'(exp_q[0].wb));
            end else begin
                check("WB_ENOut_empty", 64'(WB_ENOut), 64'd0);
            end
`ifdef MEM_WB_STALL_CNT_EN
            check("stallCountOut", 64'(stallCountOut), 64'(stall_m));
`endif
        end
    end

    // Present one cycle of inputs at the falling edge, return at the next falling edge.
    task automatic cyc(input logic v, input logic wb, input logic mr, input logic [3:0] d,
                       input logic [N-1:0] alu, input logic [N-1:0] dm,
                       input logic rdy, input logic fl);
        validIn      = v;
        WB_ENIn      = wb;
        MEM_R_ENIn   = mr;
        DestIn       = d;
        ALU_ResIn    = alu;
        DataMemoryIn = dm;
        readyIn      = rdy;
        flush        = fl;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 4'd0, '0, '0, 1'b1, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        validIn = 0; WB_ENIn = 0; MEM_R_ENIn = 0; DestIn = 0;
        ALU_ResIn = 0; DataMemoryIn = 0; flush = 0; readyIn = 0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_validOut", 64'(validOut), 64'd0);
        check("rst_readyOut", 64'(readyOut), 64'd1);
        check("rst_WB_ENOut", 64'(WB_ENOut), 64'd0);
        check("rst_DestOut", 64'(DestOut), 64'd0);
        check("rst_WB_ValueOut", 64'(WB_ValueOut), 64'd0);
        check("rst_MEM_R_ENOut", 64'(MEM_R_ENOut), 64'd0);
        rst = 1'b0;

        // Single load: value comes from data memory.
        cyc(1'b1, 1'b1, 1'b1, 4'd3, 32'h400, 32'hAA, 1'b1, 1'b0);
        check("load_validOut", 64'(validOut), 64'd1);
        check("load_value", 64'(WB_ValueOut), 64'hAA);
        check("load_dest", 64'(DestOut), 64'd3);
        check("load_wben", 64'(WB_ENOut), 64'd1);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, '0, '0, 1'b1, 1'b0);
        check("load_drained", 64'(validOut), 64'd0);

        // Back-pressure: A and B held, C refused, A stays on the outputs.
        cyc(1'b1, 1'b1, 1'b0, 4'd1, 32'h111, 32'hDEAD, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 4'd2, 32'hBEEF, 32'h222, 1'b0, 1'b0);
        check("bp_readyOut_after_B", 64'(readyOut), 64'd0);
        check("bp_A_shown", 64'(WB_ValueOut), 64'h111);
        cyc(1'b1, 1'b0, 1'b0, 4'd4, 32'h333, 32'h0, 1'b0, 1'b0);
        check("bp_C_refused", 64'(readyOut), 64'd0);
        check("bp_A_stable", 64'(WB_ValueOut), 64'h111);
        check("bp_A_dest", 64'(DestOut), 64'd1);
        // Release: A, B, C retire in order.
        cyc(1'b1, 1'b0, 1'b0, 4'd4, 32'h333, 32'h0, 1'b1, 1'b0);
        check("rel_B", 64'(WB_ValueOut), 64'h222);
        cyc(1'b1, 1'b0, 1'b0, 4'd4, 32'h333, 32'h0, 1'b1, 1'b0);
        check("rel_C", 64'(WB_ValueOut), 64'h333);
        check("rel_C_valid", 64'(validOut), 64'd1);
        check("rel_C_wben_low", 64'(WB_ENOut), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, '0, '0, 1'b1, 1'b0);
        check("rel_empty", 64'(validOut), 64'd0);

        // Flush from FULL beats a simultaneous retire.
        cyc(1'b1, 1'b1, 1'b0, 4'd5, 32'h55, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 4'd6, 32'h66, 32'h0, 1'b0, 1'b0);
        check("fl_full", 64'(readyOut), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, '0, '0, 1'b1, 1'b1);
        check("fl_validOut", 64'(validOut), 64'd0);
        check("fl_WB_ENOut", 64'(WB_ENOut), 64'd0);
        check("fl_readyOut", 64'(readyOut), 64'd1);

`ifdef MEM_WB_STALL_CNT_EN
        do_reset();
        check("cnt_after_rst0", 64'(stallCountOut), 64'd0);
        cyc(1'b1, 1'b1, 1'b0, 4'd1, 32'h1, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 4'd2, 32'h2, 32'h0, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 4'd3, 32'h3, 32'h0, 1'b0, 1'b0);
        check("cnt_five", 64'(stallCountOut), 64'd5);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
        check("cnt_after_flush", 64'(stallCountOut), 64'd5);
        do_reset();
        check("cnt_after_rst", 64'(stallCountOut), 64'd0);
`endif

        // Mid-operation reset from FULL discards both entries.
        cyc(1'b1, 1'b1, 1'b0, 4'd7, 32'h77, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 4'd8, 32'h88, 32'h0, 1'b0, 1'b0);
        do_reset();
        check("midrst_validOut", 64'(validOut), 64'd0);
        check("midrst_readyOut", 64'(readyOut), 64'd1);

        // Randomized traffic checked by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                4'($urandom), $urandom, $urandom,
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
        end
        rst = 1'b0;
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 4'd0, '0, '0, 1'b1, 1'b0);
        check("final_drained", 64'(validOut), 64'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid.md
MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 SHALL have parameter N, default 32, data path width.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port validIn  input  1  MEM stage presents an instruction this cycle.
REQ-005 SHALL have port readyOut  output  1  block can accept an instruction this cycle.
REQ-006 SHALL have port WB_ENIn  input  1  instruction writes the register file.
REQ-007 SHALL have port MEM_R_ENIn  input  1  instruction is a load.
REQ-008 SHALL have port DestIn  input  4  destination register index.
REQ-009 SHALL have port ALU_ResIn  input  N  ALU result or address from the MEM stage.
REQ-010 SHALL have port DataMemoryIn  input  N  data memory read result.
REQ-011 SHALL have port flush  input  1  discard all held instructions.
REQ-012 SHALL have port validOut  output  1  write-back entry presented to the WB consumer.
REQ-013 SHALL have port readyIn  input  1  WB consumer accepts the presented entry.
REQ-014 SHALL have port WB_ENOut  output  1  register file write enable, gated by validOut.
REQ-015 SHALL have port MEM_R_ENOut  output  1  held entry is a load.
REQ-016 SHALL have port DestOut  output  4  held destination register index.
REQ-017 SHALL have port WB_ValueOut  output  N  value to write to the register file.

Function
REQ-018 SHALL hold up to two entries, a main register and a skid register, tracked by state EMPTY, ONE or FULL.
REQ-019 SHALL accept an input when validIn and readyOut are both high, and retire an output when validOut and readyIn are both high.
REQ-020 SHALL drive readyOut high exactly when state is not FULL; readyOut SHALL depend on registered state only, with no combinational path from readyIn.
REQ-021 SHALL drive validOut high exactly when state is not EMPTY.
REQ-022 SHALL compute the stored value at capture time as DataMemoryIn when MEM_R_ENIn is 1, else ALU_ResIn.
REQ-023 SHALL make these transitions: EMPTY with accept goes to ONE, loading main.
REQ-024 SHALL make these transitions from ONE: accept only goes to FULL, loading skid; retire only goes to EMPTY; accept and retire together stay in ONE, loading main with the new input.
REQ-025 SHALL make these transitions from FULL: retire goes to ONE, moving skid into main; no accept is possible in FULL.
REQ-026 SHALL keep all outputs stable while validOut is high and readyIn is low.
REQ-027 SHALL drive WB_ENOut as main WB_EN AND validOut, so it is never high when the block is empty.
REQ-028 SHALL drive DestOut, MEM_R_ENOut and WB_ValueOut from the main register.
REQ-029 SHALL give a latency of one cycle from accept in EMPTY to validOut high, and zero bubbles under continuous validIn and readyIn.
REQ-030 SHALL give flush priority over accept and retire in the same cycle, forcing state EMPTY on the next edge; held data may be stale, but WB_ENOut SHALL be 0.
REQ-031 SHALL preserve entry order in all states (first in, first out).

Reset
REQ-032 SHALL, in any cycle with rst high, ignore validIn, readyIn and flush, and go to state EMPTY on that edge.
REQ-033 SHALL reset all outputs and registers to 0, except readyOut, which is 1 after reset (state EMPTY).
REQ-034 SHALL return to EMPTY on a reset asserted mid-operation, including in FULL, discarding both entries.

Configuration
REQ-035 SHALL, when macro MEM_WB_STALL_CNT_EN is defined, add port stallCountOut  output  16, counting cycles with validIn high and readyOut low; the count saturates at 0xFFFF, is cleared by rst only, and is not cleared by flush.
REQ-036 SHALL, without MEM_WB_STALL_CNT_EN, have no stallCountOut port and no counter logic, with all other behaviour identical.

Verification
REQ-037 SHALL pass this case: reset, then one load with validIn=1, MEM_R_ENIn=1, DataMemoryIn=0x000000AA, ALU_ResIn=0x400, DestIn=3, readyIn=1 -> next cycle validOut=1, WB_ValueOut=0xAA, DestOut=3, WB_ENOut=1.
REQ-038 SHALL pass this case: readyIn=0 with three back-to-back inputs A, B, C -> A and B are held; readyOut goes 0 after B; C is not accepted; the outputs show A stable.
REQ-039 SHALL pass this case: continuing REQ-038, raise readyIn=1 -> A, B, C retire in order, one per cycle, with no bubble once C is accepted.
REQ-040 SHALL pass this case: state FULL, then flush=1 together with readyIn=1 -> next cycle validOut=0, WB_ENOut=0, readyOut=1; no entry is retired.
REQ-041 SHALL pass this case: with MEM_WB_STALL_CNT_EN defined, hold FULL with validIn=1 for 5 cycles -> stallCountOut=5, still 5 after flush, and 0 after rst.
